// File: rtl/tone_seq_pkg.sv
// Shared types and constants for the tone sequencer: FSM state encoding,
// sample width, saturation limits and the mixer width helper.
package tone_seq_pkg;

   typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

   localparam int SAMPLE_W = 32;
   localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 32'sh7FFF_FFFF;
   localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 32'sh8000_0000;

   // Headroom for summing audio_in with n full-scale voices.
   function automatic int mix_width(input int n);
      return SAMPLE_W + $clog2(n + 1);
   endfunction

endpackage

// File: rtl/tone_sequencer_voice.sv
// square_voice: one square-wave voice with its own half-period register,
// cycle counter and phase. half==0 is a rest (silent, counter parked at 0).
module square_voice #(
   parameter int HALF_W = 19
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [HALF_W-1:0] half,
   input  logic              load,
   input  logic              clear,
   input  logic              enable,
   output logic              phase,
   output logic              active
);

   logic [HALF_W-1:0] half_q;
   logic [HALF_W-1:0] cnt;

   assign active = (half_q != '0);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         half_q <= '0;
         cnt    <= '0;
         phase  <= 1'b1;
      end else if (load && (half != half_q)) begin
         // A new note restarts the waveform; a repeated note stays phase-continuous.
         half_q <= half;
         cnt    <= '0;
         phase  <= 1'b1;
      end else if (half_q == '0) begin
         cnt    <= '0;
         phase  <= 1'b1;
      end else if (enable) begin
         if (cnt == half_q) begin
            cnt   <= '0;
            phase <= ~phase;
         end else begin
            cnt   <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tone_sequencer.sv
// Multi-voice square-wave note sequencer with saturating mix onto audio_in.
// Optional articulation gap at the end of every line: define TONE_SEQ_GAP_EN.
module tone_sequencer
   import tone_seq_pkg::*;
#(
   parameter int NUM_VOICES = 2,
   parameter int ADDR_W     = 10,
   parameter int HALF_W     = 19,
   parameter int TEMPO_W    = 27,
   parameter int VOICE_AMP  = 500000000,
   parameter int GAP_CYCLES = 500000
) (
   input  logic                         CLOCK_50,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         stop,
   input  logic                         loop_en,
   input  logic [ADDR_W-1:0]            last_line,
   input  logic [ADDR_W-1:0]            tempo_switch_line,
   input  logic [TEMPO_W-1:0]           beat_len_a,
   input  logic [TEMPO_W-1:0]           beat_len_b,
   input  logic [NUM_VOICES-1:0]        voice_mask,
   output logic [ADDR_W-1:0]            rom_addr,
   input  logic [NUM_VOICES*HALF_W-1:0] rom_q,
   input  logic signed [SAMPLE_W-1:0]   audio_in,
   output logic signed [SAMPLE_W-1:0]   sample_out,
   output logic                         playing,
   output logic                         line_strobe
);

   localparam int MIX_W = mix_width(NUM_VOICES);
   localparam logic signed [MIX_W-1:0] AMP   = MIX_W'(VOICE_AMP);
   localparam logic signed [MIX_W-1:0] MAX_X = MIX_W'(SAT_MAX);
   localparam logic signed [MIX_W-1:0] MIN_X = MIX_W'(SAT_MIN);

   state_t               state, state_n;
   logic [ADDR_W-1:0]    rom_addr_n;
   logic [TEMPO_W-1:0]   beat_cnt, beat_cnt_n, beat_len, beat_len_n;
   logic [TEMPO_W-1:0]   beat_next;
   logic                 load, clear, line_end, gap;

   // beat_next is the beat index of the current PLAY cycle (1..beat_len).
   assign beat_next   = beat_cnt + 1'b1;
   assign line_end    = (state == PLAY) && (beat_next >= beat_len);
   assign playing     = (state != IDLE);
   assign line_strobe = (state == LOAD);

   always_comb begin
      state_n    = state;
      rom_addr_n = rom_addr;
      beat_cnt_n = beat_cnt;
      beat_len_n = beat_len;
      load       = 1'b0;
      clear      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n    = FETCH;
               rom_addr_n = '0;
            end
         end
         FETCH: state_n = LOAD;
         LOAD: begin
            load       = 1'b1;
            beat_cnt_n = '0;
            beat_len_n = (rom_addr <= tempo_switch_line) ? beat_len_a : beat_len_b;
            state_n    = PLAY;
         end
         PLAY: begin
            beat_cnt_n = beat_next;
            if (line_end) begin
               if (rom_addr != last_line) begin
                  rom_addr_n = rom_addr + 1'b1;
                  state_n    = FETCH;
               end else if (loop_en) begin
                  rom_addr_n = '0;
                  state_n    = FETCH;
               end else begin
                  rom_addr_n = '0;
                  state_n    = IDLE;
                  clear      = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      if (start && (state != IDLE)) begin
         state_n    = FETCH;
         rom_addr_n = '0;
      end
      // stop dominates start and every other transition
      if (stop) begin
         state_n    = IDLE;
         rom_addr_n = '0;
         clear      = 1'b1;
         load       = 1'b0;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state    <= IDLE;
         rom_addr <= '0;
         beat_cnt <= '0;
         beat_len <= '0;
      end else begin
         state    <= state_n;
         rom_addr <= rom_addr_n;
         beat_cnt <= beat_cnt_n;
         beat_len <= beat_len_n;
      end
   end

   logic [NUM_VOICES-1:0] phase, active;

   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
      square_voice #(.HALF_W(HALF_W)) u_voice (
         .clk    (CLOCK_50),
         .reset  (reset),
         .half   (rom_q[v*HALF_W +: HALF_W]),
         .load   (load),
         .clear  (clear),
         .enable (playing),
         .phase  (phase[v]),
         .active (active[v])
      );
   end

`ifdef TONE_SEQ_GAP_EN
   // Silent while beat index > beat_len - GAP_CYCLES, done without underflow.
   assign gap = (state == PLAY) &&
                (({1'b0, beat_next} + (TEMPO_W+1)'(GAP_CYCLES)) > {1'b0, beat_len});
`else
   assign gap = 1'b0;
`endif

   logic signed [MIX_W-1:0]    sum;
   logic signed [SAMPLE_W-1:0] sat;

   always_comb begin
      sum = MIX_W'(audio_in);
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (active[v] && voice_mask[v] && !gap) begin
            sum = sum + (phase[v] ? AMP : -AMP);
         end
      end
      if (sum > MAX_X) begin
         sat = SAT_MAX;
      end else if (sum < MIN_X) begin
         sat = SAT_MIN;
      end else begin
         sat = sum[SAMPLE_W-1:0];
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sample_out <= '0;
      end else begin
         sample_out <= sat;
      end
   end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Parametrised multi-voice square-wave note sequencer.
- Reads one line per beat from a synchronous note ROM; each line holds one half-period per voice.
- Generates NUM_VOICES square waves, sums them with the live codec input, and drives a saturated 32-bit sample to the audio controller's output channels.
- Generalises the single-voice, fixed-tempo tone player: adds programmable tempo split, loop/stop control, voice masking and saturating mix.

Parameters:
- NUM_VOICES, 2, number of simultaneous square-wave voices (1..4).
- ADDR_W, 10, note ROM address width.
- HALF_W, 19, per-voice half-period field width, in clock cycles minus one.
- TEMPO_W, 27, beat-length counter width.
- VOICE_AMP, 500000000, per-voice amplitude (signed magnitude).
- GAP_CYCLES, 500000, silent articulation gap at the end of each line (optional feature only).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; start or restart playback at line 0.
- stop  in  1  one-cycle pulse; halt playback.
- loop_en  in  1  after last_line, wrap to line 0 instead of stopping.
- last_line  in  ADDR_W  index of the final ROM line.
- tempo_switch_line  in  ADDR_W  last line played at tempo A.
- beat_len_a  in  TEMPO_W  beat length for lines <= tempo_switch_line.
- beat_len_b  in  TEMPO_W  beat length for lines > tempo_switch_line.
- voice_mask  in  NUM_VOICES  1 = voice audible.
- rom_addr  out  ADDR_W  note ROM address.
- rom_q  in  NUM_VOICES*HALF_W  ROM data, valid 1 cycle after rom_addr; voice v occupies bits [v*HALF_W +: HALF_W].
- audio_in  in  32  signed codec input sample.
- sample_out  out  32  signed mixed sample.
- playing  out  1  high in every state except IDLE.
- line_strobe  out  1  one-cycle pulse in each LOAD cycle.

Behaviour:
- Reset values: rom_addr=0, sample_out=0, playing=0, line_strobe=0. All half-period registers are cleared to 0 and all phases set to +. State is IDLE.
- States: IDLE, FETCH, LOAD, PLAY.
- IDLE -> FETCH on start, with rom_addr=0.
- FETCH: holds rom_addr for exactly one cycle, then goes to LOAD.
- LOAD: latches rom_q into the per-voice half registers, pulses line_strobe, sets beat_cnt=0, then goes to PLAY.
- Beat length: beat_len = (rom_addr <= tempo_switch_line) ? beat_len_a : beat_len_b, evaluated in LOAD and held for the line.
- PLAY: beat_cnt increments each cycle. When beat_cnt == beat_len the line ends. Each line therefore occupies beat_len+2 cycles (FETCH, LOAD, PLAY).
- End of line:
  - If rom_addr != last_line: rom_addr+1, go to FETCH.
  - Else if loop_en: rom_addr=0, go to FETCH.
  - Else: go to IDLE and clear the half registers.
- stop in any state: next cycle is IDLE with the half registers cleared.
- start while playing: restart at line 0 via FETCH.
- start and stop in the same cycle: stop wins.
- Voices:
  - half==0 means rest: contribution 0, counter held at 0, phase held at +.
  - Otherwise the counter runs 0..half; at the terminal count it resets and the phase toggles. Full period = 2*(half+1) cycles.
  - In LOAD, a voice whose new half differs from the old one resets its counter to 0 and its phase to +. An unchanged voice continues phase-continuous.
- Voice contribution: phase ? +VOICE_AMP : -VOICE_AMP, gated by voice_mask[v] and half!=0.
- Mix:
  - Sum = audio_in plus all contributions, computed at 32+clog2(NUM_VOICES+1) bits.
  - Saturated to [0x80000000, 0x7FFFFFFF], then registered.
  - Latency is 1 cycle from a phase change or an audio_in change to sample_out.
- In IDLE the voices are silent, so sample_out = audio_in delayed by 1 cycle.

Optional Feature:
- Macro: TONE_SEQ_GAP_EN.
- With it defined: during the final GAP_CYCLES cycles of PLAY (beat_cnt > beat_len-GAP_CYCLES) every voice contribution is forced to 0. The counters keep running. If beat_len < GAP_CYCLES the whole line is silent.
- Without it: there is no gap logic, and the GAP_CYCLES parameter is unused.

Decomposition:
- Package tone_seq_pkg holds:
  - state enum {IDLE, FETCH, LOAD, PLAY};
  - SAMPLE_W=32;
  - SAT_MAX and SAT_MIN constants;
  - the mix-width function.
- Sub-module square_voice, instantiated NUM_VOICES times. Ports: half, load, clear, enable; outputs phase and active.
- Sequencer FSM and saturating mixer stay in tone_sequencer.

Test Plan:
- NUM_VOICES=1, ROM line0 half=3, last_line=0, loop_en=1, beat_len_a=20, audio_in=0, start -> sample_out alternates +500000000 and -500000000 every 4 cycles, starting 1 cycle after LOAD; line_strobe pulses every 22 cycles.
- tempo_switch_line=1, last_line=3, beat_len_a=10, beat_len_b=4, loop_en=0 -> line_strobe spacing is 12, 12, 6; playing drops 6 cycles after the 4th strobe; rom_addr returns to 0.
- Saturation: 2 voices in + phase, audio_in=0x7FFF0000 -> sample_out=0x7FFFFFFF. Both in - phase with audio_in=0x80010000 -> 0x80000000.
- voice_mask=2'b01 with both voices active -> only voice 0 toggles appear; voice 1 contributes 0. A ROM line with half=0 on voice 0 -> sample_out equals delayed audio_in.
- start and stop asserted together while in PLAY -> IDLE next cycle, playing=0, sample_out = delayed audio_in. Reset asserted mid-PLAY -> all outputs reach their reset values on the next edge.
- With TONE_SEQ_GAP_EN defined, GAP_CYCLES=5, beat_len_a=20 -> voice contributions are 0 for beat_cnt 16..20 of each line and resume after the next LOAD.
